rdo_sample_responder: RTL and testbench

- Single-clock responder for the RDO readout protocol. It captures a frame of NSAMPLES samples into an internal buffer.
- It answers the reader's RDO_Req/RDO_Add reads with RDO_Ack/RDO_Q, and flags end-of-frame with RDO_Done.
- It sits between a sample source (DSGEN-style generator or ADC front end) and the PlotSignal reader, for designs that need no clock crossing.

---
 rtl/rdo_pkg.sv | 17 +
 rtl/rdo_sample_ram.sv | 28 ++
 rtl/rdo_sample_responder.sv | 171 +++++++++++++++++
 tb/tb_rdo_sample_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rdo_pkg.sv
// Shared definitions for the RDO sample responder: FSM encoding, default
// geometry and the buffer read latency seen by the reader.
package rdo_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        READY   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } rdo_state_e;

    localparam int RDO_NSAMPLES_DEF  = 512;
    localparam int RDO_PRECISION_DEF = 1;
    localparam int RDO_ADD_BLEN_DEF  = 9;
    localparam int RDO_RD_LAT        = 2;

endpackage

// File: rtl/rdo_sample_ram.sv
// Frame buffer: simple dual-port RAM, one write port and one registered
// read port. No reset on the array or read register so it maps to block RAM.
module rdo_sample_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 1,
    parameter int AW    = 9
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rdo_sample_responder.sv
// RDO readout responder: captures one frame into rdo_sample_ram and serves
// four-phase Req/Ack reads. Optional drop counter: RDO_SAMPLE_RESPONDER_DROP_CNT_EN.
//
// state   | meaning
// FILL    | capturing CAP_D into buffer[wptr]; reads stalled
// READY   | frame complete; latch a request and wait out the RAM latency
// ACK     | RDO_Ack/RDO_Q held until the reader drops RDO_Req
// RELEASE | last address read: RDO_Done pulse, frame released
module rdo_sample_responder
    import rdo_pkg::*;
#(
    parameter int NSAMPLES     = RDO_NSAMPLES_DEF,
    parameter int PRECISION    = RDO_PRECISION_DEF,
    parameter int RDO_ADD_BLEN = RDO_ADD_BLEN_DEF
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [PRECISION-1:0]    CAP_D,
    input  logic                    CAP_Valid,
    input  logic [RDO_ADD_BLEN-1:0] RDO_Add,
    input  logic                    RDO_Req,
    output logic                    RDO_Ack,
    output logic [PRECISION-1:0]    RDO_Q,
    output logic                    RDO_Done,
    output logic                    FRAME_Ready
`ifdef RDO_SAMPLE_RESPONDER_DROP_CNT_EN
    ,
    output logic [15:0]             DROP_Cnt
`endif
);

    localparam logic [RDO_ADD_BLEN-1:0] LAST_ADDR = RDO_ADD_BLEN'(NSAMPLES - 1);

    rdo_state_e              state_q, state_d;
    logic [RDO_ADD_BLEN-1:0] wptr_q, wptr_d;
    logic [RDO_ADD_BLEN-1:0] addr_q, addr_d;
    logic [1:0]              lat_q, lat_d;
    logic                    busy_q, busy_d;
    logic                    ack_q, ack_d;
    logic [PRECISION-1:0]    q_q, q_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;
    logic                    we;
    logic [PRECISION-1:0]    rd_data;

    rdo_sample_ram #(
        .DEPTH (NSAMPLES),
        .WIDTH (PRECISION),
        .AW    (RDO_ADD_BLEN)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (CAP_D),
        .raddr_i (addr_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= FILL;
            wptr_q  <= '0;
            addr_q  <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            q_q     <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        busy_d  = busy_q;
        ack_d   = ack_q;
        q_d     = q_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        we      = 1'b0;
        case (state_q)
            FILL: begin
                if (CAP_Valid) begin
                    we     = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    if (wptr_q == LAST_ADDR) begin
                        state_d = READY;
                        ready_d = 1'b1;
                    end
                end
            end
            READY: begin
                // Down-counter covers the address latch plus the registered RAM read.
                if (busy_q) begin
                    if (lat_q == 2'd0) begin
                        busy_d  = 1'b0;
                        ack_d   = 1'b1;
                        q_d     = rd_data;
                        state_d = ACK;
                    end else begin
                        lat_d = lat_q - 2'd1;
                    end
                end else if (RDO_Req) begin
                    addr_d = RDO_Add;
                    busy_d = 1'b1;
                    lat_d  = 2'(RDO_RD_LAT - 1);
                end
            end
            ACK: begin
                if (!RDO_Req) begin
                    ack_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = RELEASE;
                        done_d  = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        state_d = READY;
                    end
                end
            end
            RELEASE: begin
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign RDO_Ack     = ack_q;
    assign RDO_Q       = q_q;
    assign RDO_Done    = done_q;
    assign FRAME_Ready = ready_q;

`ifdef RDO_SAMPLE_RESPONDER_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (state_q == RELEASE) begin
            drop_d = '0;
        end else if (state_q != FILL && CAP_Valid && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign DROP_Cnt = drop_q;
`endif

endmodule

// File: tb/tb_rdo_sample_responder.sv
// Scoreboard bench for rdo_sample_responder: reads push expected data and
// Ack/Done cycles, a negedge monitor pops and compares.
module tb_rdo_sample_responder;
    import rdo_pkg::*;

    localparam int N  = 512;
    localparam int AW = 9;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [0:0]    CAP_D = '0;
    logic          CAP_Valid = 1'b0;
    logic [AW-1:0] RDO_Add = '0;
    logic          RDO_Req = 1'b0;
    logic          RDO_Ack;
    logic [0:0]    RDO_Q;
    logic          RDO_Done;
    logic          FRAME_Ready;
`ifdef RDO_SAMPLE_RESPONDER_DROP_CNT_EN
    logic [15:0]   DROP_Cnt;
`endif

    rdo_sample_responder #(
        .NSAMPLES     (N),
        .PRECISION    (1),
        .RDO_ADD_BLEN (AW)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .CAP_D       (CAP_D),
        .CAP_Valid   (CAP_Valid),
        .RDO_Add     (RDO_Add),
        .RDO_Req     (RDO_Req),
        .RDO_Ack     (RDO_Ack),
        .RDO_Q       (RDO_Q),
        .RDO_Done    (RDO_Done),
        .FRAME_Ready (FRAME_Ready)
`ifdef RDO_SAMPLE_RESPONDER_DROP_CNT_EN
        ,
        .DROP_Cnt    (DROP_Cnt)
`endif
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [0:0] q;
        int         c;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    bit   exp_mem [N];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic bit pbit(input int pat, input int i);
        logic [AW-1:0] a;
        a = i[AW-1:0];
        case (pat)
            0:       return a[0];
            1:       return ~(^a);
            2:       return a[1];
            default: return ~a[0];
        endcase
    endfunction

    logic ack_prev = 1'b0;
    always @(negedge Clock) begin
        if (Reset) begin
            ack_prev = 1'b0;
        end else begin
            if (RDO_Ack && !ack_prev) begin
                chk("ack_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rdo_q", 32'(RDO_Q), 32'(e.q));
                    chk("ack_cycle", cyc, e.c);
                end
            end
            if (RDO_Done) begin
                chk("done_expected", 32'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    int d;
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d);
                end
            end
            ack_prev = RDO_Ack;
        end
    end

    task automatic fill(input int pat, input bit stall);
        for (int i = 0; i < N; i++) begin
            @(negedge Clock);
            if (i == N - 1) chk("ready_before_last", 32'(FRAME_Ready), 0);
            CAP_Valid  = 1'b1;
            CAP_D      = pbit(pat, i);
            exp_mem[i] = pbit(pat, i);
            if (stall && i == 100) begin
                RDO_Req = 1'b1;
                RDO_Add = AW'(300);
            end
            if (stall && i == N - 1) exp_q.push_back('{exp_mem[300], cyc + 4});
        end
        @(negedge Clock);
        CAP_Valid = 1'b0;
        chk("ready_after_last", 32'(FRAME_Ready), 1);
        chk("ack_during_fill", 32'(RDO_Ack), 0);
    endtask

    task automatic finish_read(input int a, input bit last);
        int k;
        int d;
        @(negedge Clock);
        RDO_Add = AW'(~a);
        k = 0;
        while (!RDO_Ack && k < 12) begin
            @(negedge Clock);
            k++;
        end
        chk("ack_seen", 32'(RDO_Ack), 1);
        @(negedge Clock);
        chk("ack_held", 32'(RDO_Ack), 1);
        RDO_Req = 1'b0;
        d = cyc;
        if (last) done_q.push_back(d + 1);
        @(negedge Clock);
        chk("ack_drop", 32'(RDO_Ack), 0);
        if (last) chk("ready_at_release", 32'(FRAME_Ready), 0);
    endtask

    task automatic do_read(input int a, input bit last);
        @(negedge Clock);
        RDO_Req = 1'b1;
        RDO_Add = AW'(a);
        exp_q.push_back('{exp_mem[a], cyc + 3});
        finish_read(a, last);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge Clock);
        chk("rst_ack", 32'(RDO_Ack), 0);
        chk("rst_q", 32'(RDO_Q), 0);
        chk("rst_done", 32'(RDO_Done), 0);
        chk("rst_ready", 32'(FRAME_Ready), 0);
        Reset = 1'b0;

        // Frame 1: address[0] pattern, then samples that must be dropped.
        fill(0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            CAP_Valid = 1'b1;
            CAP_D     = ~exp_mem[i];
        end
        @(negedge Clock);
        CAP_Valid = 1'b0;
`ifdef RDO_SAMPLE_RESPONDER_DROP_CNT_EN
        chk("drop_cnt_10", 32'(DROP_Cnt), 10);
`endif
        do_read(5, 1'b0);
        for (int i = 0; i < N; i++) do_read(i, i == N - 1);
        // Sample offered in the RELEASE cycle must be discarded.
        CAP_Valid = 1'b1;
        CAP_D     = 1'b0;

        // Frame 2: request held from wptr=100 stalls until the frame is full.
        fill(1, 1'b1);
`ifdef RDO_SAMPLE_RESPONDER_DROP_CNT_EN
        chk("drop_cnt_cleared", 32'(DROP_Cnt), 0);
`endif
        finish_read(300, 1'b0);
        do_read(0, 1'b0);
        do_read(7, 1'b0);
        do_read(511, 1'b1);

        // Frame 3: asynchronous reset while Ack is high.
        fill(2, 1'b0);
        @(negedge Clock);
        RDO_Req = 1'b1;
        RDO_Add = AW'(300);
        exp_q.push_back('{exp_mem[300], cyc + 3});
        for (int k = 0; k < 12 && !RDO_Ack; k++) @(negedge Clock);
        chk("ack_before_reset", 32'(RDO_Ack), 1);
        #2 Reset = 1'b1;
        #1;
        chk("arst_ack", 32'(RDO_Ack), 0);
        chk("arst_q", 32'(RDO_Q), 0);
        chk("arst_ready", 32'(FRAME_Ready), 0);
        chk("arst_done", 32'(RDO_Done), 0);
        RDO_Req = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("post_reset_ready", 32'(FRAME_Ready), 0);

        // Frame 4: refill from wptr=0 after reset.
        fill(3, 1'b0);
        do_read(0, 1'b0);
        do_read(300, 1'b0);
        do_read(511, 1'b1);
        @(negedge Clock);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
